// File: rtl/bolt_pkg.sv
// Shared types and helpers for the bolt pool: coordinate width, slot state
// and the fixed-point to pixel conversion.
package bolt_pkg;

    localparam int COORD_W   = 11;
    localparam int FIX_MAX_W = 32;

    typedef enum logic {
        SLOT_FREE   = 1'b0,
        SLOT_FLYING = 1'b1
    } slot_state_t;

    // Floor shift of a sign-extended fixed-point value, truncated to a pixel.
    function automatic logic [COORD_W-1:0] to_pixel(input logic signed [FIX_MAX_W-1:0] fixed,
                                                     input int frac_bits);
        logic signed [FIX_MAX_W-1:0] shifted;
        shifted = fixed >>> frac_bits;
        return shifted[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/bolt_pool_move_slot.sv
// One bolt slot: FREE/FLYING state plus fixed-point position, moved once per
// frame and retired on kill or when its integer Y leaves [Y_MIN, Y_MAX].
module bolt_slot
    import bolt_pkg::*;
#(
    parameter int FRAC_BITS = 6,
    parameter int FIX_W     = COORD_W + FRAC_BITS + 2,
    parameter int DELTA_Y   = -640,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      load,
    input  logic signed [FIX_W-1:0]   loadX,
    input  logic signed [FIX_W-1:0]   loadY,
    input  logic                      move,
    input  logic                      kill,
    output logic                      active,
    output logic [COORD_W-1:0]        pixX,
    output logic [COORD_W-1:0]        pixY
);

    localparam int INT_W = FIX_W - FRAC_BITS;
    localparam logic signed [FIX_W-1:0] DELTA_S = FIX_W'(DELTA_Y);
    localparam logic signed [INT_W-1:0] Y_MIN_S = INT_W'(Y_MIN);
    localparam logic signed [INT_W-1:0] Y_MAX_S = INT_W'(Y_MAX);

    slot_state_t               state_r, state_n;
    logic signed [FIX_W-1:0]   pos_x_r, pos_x_n;
    logic signed [FIX_W-1:0]   pos_y_r, pos_y_n;
    logic signed [FIX_W-1:0]   moved_y_s;
    logic signed [INT_W-1:0]   moved_int_s;
    logic                      off_screen_s;

    // The high bits of a two's-complement value are its floor integer part.
    assign moved_y_s    = pos_y_r + DELTA_S;
    assign moved_int_s  = moved_y_s[FIX_W-1:FRAC_BITS];
    assign off_screen_s = (moved_int_s < Y_MIN_S) || (moved_int_s > Y_MAX_S);

    // Slot state and position registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r <= SLOT_FREE;
            pos_x_r <= '0;
            pos_y_r <= '0;
        end else begin
            state_r <= state_n;
            pos_x_r <= pos_x_n;
            pos_y_r <= pos_y_n;
        end
    end

    // Next state: kill beats movement; a freed slot's position is cleared.
    always_comb begin
        state_n = state_r;
        pos_x_n = pos_x_r;
        pos_y_n = pos_y_r;
        case (state_r)
            SLOT_FREE: begin
                if (load) begin
                    state_n = SLOT_FLYING;
                    pos_x_n = loadX;
                    pos_y_n = loadY;
                end else begin
                    state_n = SLOT_FREE;
                end
            end
            SLOT_FLYING: begin
                if (kill) begin
                    state_n = SLOT_FREE;
                    pos_x_n = '0;
                    pos_y_n = '0;
                end else if (move) begin
                    if (off_screen_s) begin
                        state_n = SLOT_FREE;
                        pos_x_n = '0;
                        pos_y_n = '0;
                    end else begin
                        pos_y_n = moved_y_s;
                    end
                end else begin
                    state_n = SLOT_FLYING;
                end
            end
            default: begin
                state_n = SLOT_FREE;
                pos_x_n = '0;
                pos_y_n = '0;
            end
        endcase
    end

    assign active = (state_r == SLOT_FLYING);
    assign pixX   = active ? to_pixel(FIX_MAX_W'(pos_x_r), FRAC_BITS) : '0;
    assign pixY   = active ? to_pixel(FIX_MAX_W'(pos_y_r), FRAC_BITS) : '0;

endmodule

// File: rtl/bolt_pool_move.sv
// Pool of NUM_BOLTS bolt slots with launch arbitration and frame cooldown.
// Optional macro BOLT_AUTOFIRE_EN makes shootReq level-sensitive (autofire).
module bolt_pool_move
    import bolt_pkg::*;
#(
    parameter int NUM_BOLTS       = 4,
    parameter int DIRECTION       = -1,
    parameter int SPEED_Y         = 10,
    parameter int OFFSET_X        = 0,
    parameter int OFFSET_Y        = 0,
    parameter int FRAC_BITS       = 6,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 479,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           startOfFrame,
    input  logic                           shootReq,
    input  logic [COORD_W-1:0]             init_x,
    input  logic [COORD_W-1:0]             init_y,
    input  logic [NUM_BOLTS-1:0]           hit,
    output logic                           shootAck,
    output logic [NUM_BOLTS-1:0]           activeBolts,
    output logic [NUM_BOLTS*COORD_W-1:0]   topLeftX,
    output logic [NUM_BOLTS*COORD_W-1:0]   topLeftY
);

    localparam int FIX_W   = COORD_W + FRAC_BITS + 2;
    localparam int DELTA_Y = SPEED_Y * DIRECTION * (1 << FRAC_BITS);
    localparam int CD_W    = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

    logic [NUM_BOLTS-1:0]      active_s;
    logic [NUM_BOLTS-1:0]      first_free_s;
    logic [NUM_BOLTS-1:0]      load_s;
    logic [COORD_W-1:0]        pix_x_s [NUM_BOLTS];
    logic [COORD_W-1:0]        pix_y_s [NUM_BOLTS];
    logic [CD_W-1:0]           cooldown_r;
    logic                      shoot_ack_r;
    logic                      armed_s;
    logic                      any_free_s;
    logic                      accept_s;
    logic signed [FIX_W-1:0]   load_x_s;
    logic signed [FIX_W-1:0]   load_y_s;

`ifdef BOLT_AUTOFIRE_EN
    assign armed_s = 1'b1;
`else
    logic armed_r;

    // Edge qualification: re-arm only after shootReq has been seen low.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            armed_r <= 1'b1;
        end else if (accept_s) begin
            armed_r <= 1'b0;
        end else if (!shootReq) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

    assign armed_s = armed_r;
`endif

    assign any_free_s = ~(&active_s);
    assign accept_s   = shootReq && (cooldown_r == '0) && any_free_s && armed_s;
    assign load_s     = first_free_s & {NUM_BOLTS{accept_s}};
    assign load_x_s   = (FIX_W'(init_x) + FIX_W'(OFFSET_X)) <<< FRAC_BITS;
    assign load_y_s   = (FIX_W'(init_y) + FIX_W'(OFFSET_Y)) <<< FRAC_BITS;

    // Lowest-index free slot, one-hot, from registered slot state only.
    always_comb begin
        first_free_s = '0;
        for (int i = NUM_BOLTS - 1; i >= 0; i--) begin
            if (!active_s[i]) begin
                first_free_s    = '0;
                first_free_s[i] = 1'b1;
            end else begin
                first_free_s = first_free_s;
            end
        end
    end

    // Cooldown load on launch wins over the per-frame decrement.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cooldown_r  <= '0;
            shoot_ack_r <= 1'b0;
        end else begin
            shoot_ack_r <= accept_s;
            if (accept_s) begin
                cooldown_r <= CD_LOAD;
            end else if (startOfFrame && (cooldown_r != '0)) begin
                cooldown_r <= cooldown_r - CD_W'(1);
            end else begin
                cooldown_r <= cooldown_r;
            end
        end
    end

    for (genvar g = 0; g < NUM_BOLTS; g++) begin : g_slot
        bolt_slot #(
            .FRAC_BITS (FRAC_BITS),
            .FIX_W     (FIX_W),
            .DELTA_Y   (DELTA_Y),
            .Y_MIN     (Y_MIN),
            .Y_MAX     (Y_MAX)
        ) u_slot (
            .clk    (clk),
            .resetN (resetN),
            .load   (load_s[g]),
            .loadX  (load_x_s),
            .loadY  (load_y_s),
            .move   (startOfFrame),
            .kill   (hit[g]),
            .active (active_s[g]),
            .pixX   (pix_x_s[g]),
            .pixY   (pix_y_s[g])
        );
        assign topLeftX[g*COORD_W +: COORD_W] = pix_x_s[g];
        assign topLeftY[g*COORD_W +: COORD_W] = pix_y_s[g];
    end

    assign shootAck    = shoot_ack_r;
    assign activeBolts = active_s;

endmodule
